// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the commit-trace capture block.
//   - Trace record geometry (56 bits: seq, type, reserved, address, data).
//   - Record type codes and the sequence-number width.
//   - pack_record(): builds one record from its fields.
package trace_pkg;

  localparam int SEQ_W  = 8;
  localparam int TYPE_W = 2;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int REC_W  = 56;

  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = 32;
  localparam int RSVD_LSB = 44;
  localparam int TYPE_LSB = 46;
  localparam int SEQ_LSB  = 48;

  localparam logic [TYPE_W-1:0] TRC_REG = 2'b01;
  localparam logic [TYPE_W-1:0] TRC_MEM = 2'b10;

  function automatic logic [REC_W-1:0] pack_record(
    input logic [SEQ_W-1:0]  seq,
    input logic [TYPE_W-1:0] typ,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] dat
  );
    logic [REC_W-1:0] rec;
    rec = '0;
    rec[SEQ_LSB  +: SEQ_W]  = seq;
    rec[TYPE_LSB +: TYPE_W] = typ;
    rec[ADDR_LSB +: ADDR_W] = addr;
    rec[DATA_LSB +: DATA_W] = dat;
    return rec;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: first-word fall-through FIFO with two push ports and one pop.
//   clock, reset      : clock and synchronous active-high reset (flushes pointers/count)
//   push0/push0_data  : first record pushed this cycle
//   push1/push1_data  : second record; only meaningful together with push0
//   pop               : remove head record (ignored when empty)
//   head_data         : head record, valid whenever valid = 1
//   valid, count, full, empty : occupancy status (derived from count only)
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 56
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push0,
  input  logic [W-1:0]             push0_data,
  input  logic                     push1,
  input  logic [W-1:0]             push1_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_reg, rptr_reg;
  logic [AW:0]   count_reg;
  logic          pop_ok;

  assign pop_ok = pop && (count_reg != '0);

  // Storage is not reset; pointers/count define what is live.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (push0) mem[wptr_reg] <= push0_data;
      if (push1) mem[wptr_reg + AW'(1)] <= push1_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      wptr_reg  <= wptr_reg + AW'(push0) + AW'(push1);
      rptr_reg  <= rptr_reg + AW'(pop_ok);
      count_reg <= count_reg + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop_ok);
    end
  end

  // Asynchronous read of the head gives fall-through behaviour.
  assign head_data = mem[rptr_reg];
  assign count     = count_reg;
  assign valid     = (count_reg != '0);
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (AW+1)'(DEPTH));

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: snoops regfile and dmem writes on each commit strobe,
// packs them into 56-bit trace records and buffers them for a valid/ready
// consumer. Records that do not fit are counted in drop_count.
//   clock, reset                  : clock, synchronous active-high reset
//   sample_en                     : commit strobe; all snooped inputs ignored without it
//   ctrl_writeEnable/_writeReg,
//   data_writeReg                 : regfile write port snoop
//   wren, address_dmem, data      : dmem write port snoop
//   out_valid/out_ready/out_data  : FWFT record stream
//   count, full, empty            : FIFO occupancy
//   drop_count                    : saturating count of dropped records
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sample_en,
  input  logic                   ctrl_writeEnable,
  input  logic [4:0]             ctrl_writeReg,
  input  logic [31:0]            data_writeReg,
  input  logic                   wren,
  input  logic [11:0]            address_dmem,
  input  logic [31:0]            data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [REC_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              reg_ev, mem_ev, pop;
  logic              reg_acc, mem_acc;
  logic [CW:0]       free_slots, mem_need;
  logic [1:0]        drops;
  logic [SEQ_W-1:0]  seq_reg, seq_next, mem_seq;
  logic [DROP_W-1:0] drop_count_reg;
  logic [DROP_W:0]   drop_sum;
  logic [REC_W-1:0]  reg_rec, mem_rec;
  logic              push0, push1;
  logic [REC_W-1:0]  push0_data;

  assign reg_ev = sample_en && ctrl_writeEnable && (ctrl_writeReg != 5'd0);
  assign mem_ev = sample_en && wren;
  assign pop    = out_valid && out_ready;

  // A pop in this cycle frees its slot for a push in the same cycle.
  assign free_slots = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(pop);

  // Reg record has priority for the last free slot.
  assign reg_acc  = reg_ev && (free_slots != '0);
  assign mem_need = reg_acc ? (CW+1)'(2) : (CW+1)'(1);
  assign mem_acc  = mem_ev && (free_slots >= mem_need);
  assign drops    = 2'(reg_ev && !reg_acc) + 2'(mem_ev && !mem_acc);

  // Seq advances per event regardless of acceptance, so drops leave gaps.
  assign mem_seq  = seq_reg + SEQ_W'(reg_ev);
  assign seq_next = mem_seq + SEQ_W'(mem_ev);

  assign reg_rec = pack_record(seq_reg, TRC_REG, {7'd0, ctrl_writeReg}, data_writeReg);
  assign mem_rec = pack_record(mem_seq, TRC_MEM, address_dmem, data);

  // Compact accepted records onto the FIFO push ports in reg-then-mem order.
  assign push0      = reg_acc || mem_acc;
  assign push0_data = reg_acc ? reg_rec : mem_rec;
  assign push1      = reg_acc && mem_acc;

  assign drop_sum = {1'b0, drop_count_reg} + (DROP_W+1)'(drops);

  always_ff @(posedge clock) begin
    if (reset) begin
      seq_reg        <= '0;
      drop_count_reg <= '0;
    end else begin
      seq_reg <= seq_next;
      if (drop_sum[DROP_W]) drop_count_reg <= '1;
      else                  drop_count_reg <= drop_sum[DROP_W-1:0];
    end
  end

  assign drop_count = drop_count_reg;

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push0      (push0),
    .push0_data (push0_data),
    .push1      (push1),
    .push1_data (mem_rec),
    .pop        (pop),
    .head_data  (out_data),
    .valid      (out_valid),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Commit-trace capture stage that sits directly downstream of the processor/regfile/dmem top level. On each processor commit strobe it snoops the regfile write port and the dmem write port, packs every architectural write into a 56-bit trace record, and buffers the records in a FIFO. A debug or test-harness consumer drains them over a valid/ready stream. Buffer overflow is never silent: dropped records are counted and leave gaps in the sequence numbers.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 4.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clock  in  1  single clock for the whole block (the fast base clock, not a divided clock).
- reset  in  1  synchronous, active-high.
- sample_en  in  1  one-cycle strobe marking the processor commit edge; once per processor_clock period.
- ctrl_writeEnable  in  1  regfile write enable.
- ctrl_writeReg  in  5  regfile destination.
- data_writeReg  in  32  regfile write data.
- wren  in  1  dmem write enable.
- address_dmem  in  12  dmem address.
- data  in  32  dmem write data.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts the head record.
- out_data  out  56  head record.
- count  out  $clog2(DEPTH)+1  occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- drop_count  out  DROP_W  records lost to overflow; saturates at all-ones.

## Operation
- Reg event: sample_en && ctrl_writeEnable && ctrl_writeReg != 0. Writes to $r0 are not traced.
- Mem event: sample_en && wren.
- Record layout:
  - [55:48] seq.
  - [47:46] type: 01 = reg, 10 = mem.
  - [45:44] 0.
  - [43:32] address: reg number zero-extended to 12 bits, or address_dmem.
  - [31:0] data.
- Both events in the same sample produce two records in the order reg, then mem. The reg record gets seq and the mem record gets seq+1.
- seq is an 8-bit counter that advances once per event, whether the event is accepted or dropped. It wraps 255 → 0.
- Free slots = DEPTH − count + (pop this cycle). A pop is out_valid && out_ready.
- Records are accepted in order while free slots remain. The reg record wins the last slot, and the mem record is then dropped.
- Each dropped record increments drop_count by 1 (saturating). A double drop in one cycle adds 2, also saturating.
- The stream is first-word fall-through: out_data holds the head record whenever out_valid = 1. out_data is don't-care when out_valid = 0, and the bench checks it only when valid.
- Without sample_en, the snooped inputs are ignored entirely.

## Timing
- Reset values: out_valid 0, count 0, empty 1, full 0, drop_count 0, seq 0, pointers 0. FIFO contents are not cleared.
- Reset mid-operation flushes all buffered records on that edge, and pushes or pops in the reset cycle are discarded.
- Latency: an event sampled at edge N is visible on out_valid/out_data after edge N (registered). Into an empty FIFO, this means out_valid = 1 in cycle N+1.
- Throughput: up to 2 pushes and 1 pop per cycle. count updates by +pushes − pop.
- Simultaneous pop and push when full: the pop frees a slot in the same cycle, so one push is accepted and no drop occurs.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally. full/empty derive from count, never from pointer compare.
- out_valid only deasserts through a pop or a reset.

## Structure
- Package trace_pkg holds:
  - record field widths and offsets;
  - the type codes TRC_REG = 2'b01 and TRC_MEM = 2'b10;
  - the SEQ_W = 8 constant;
  - a pack function.
- Sub-module trace_fifo holds the dual-push, single-pop FWFT storage with count. The top level holds event decode, seq, the drop counter and record packing.

## Test plan
- Single reg write: sample_en with reg 5 = 0xDEADBEEF → after 1 cycle out_valid = 1 and out_data = seq 0, type 01, addr 0x005, data 0xDEADBEEF. With out_ready = 1, count returns to 0.
- Paired events: one sample with reg 3 = 0x11 and mem 0x0A4 = 0x22 → two records in order, seq 0 then seq 1, types 01 then 10. $r0 writes and samples without sample_en produce nothing.
- Overflow: DEPTH = 16 with out_ready = 0, 17 reg events → count 16, full = 1, drop_count 1. Draining then yields seq 0..15, and the next accepted record carries seq 17.
- Full plus pop plus push in one cycle → no drop and count stays 16. Full with a paired event and a pop → reg record accepted, mem dropped, drop_count +1.
- Wrap and saturation: 300 events drained continuously → seq wraps 255 → 0 with pointers wrapping cleanly. drop_count forced near the maximum holds at all-ones.
- Reset asserted with 5 records queued → next cycle out_valid 0, count 0, drop_count 0. The first new record carries seq 0.
